bf_program_loader: RTL and testbench

BF_PROGRAM_LOADER -- requirements
Module: bf_program_loader

---
 rtl/bf_program_loader.sv | 123 ++++++++++++
 tb/tb_bf_program_loader.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/bf_program_loader.sv
// Streams ASCII Brainfuck text into a program RAM. Non-command bytes are filtered out
// and a 0x00 terminator is appended; bracket balance and capacity overflow are flagged.
module bf_program_loader #(
  parameter int SIZE      = 512,
  parameter int ADDR_SIZE = 9
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic [7:0]           in_data,
  output logic                 in_ready,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic [7:0]           ram_data,
  output logic                 ram_write,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
  output logic                 unbalanced,
  output logic [ADDR_SIZE:0]   length
);

  typedef enum logic [2:0] {IDLE, LOAD, TERM, SETTLE, DONE} state_t;

  state_t                 state_q, state_d;
  logic [ADDR_SIZE:0]     length_q, length_d;
  logic [ADDR_SIZE-1:0]   depth_q, depth_d;
  logic                   overflow_q, overflow_d;
  logic                   unbalanced_q, unbalanced_d;
  logic [ADDR_SIZE-1:0]   ram_addr_q, ram_addr_d;
  logic [7:0]             ram_data_q, ram_data_d;
  logic                   ram_write_q, ram_write_d;

  logic accept, is_cmd, full;

  assign accept = in_valid && (state_q == LOAD);
  assign is_cmd = (in_data == 8'h2B) || (in_data == 8'h2D) || (in_data == 8'h3C) ||
                  (in_data == 8'h3E) || (in_data == 8'h5B) || (in_data == 8'h5D) ||
                  (in_data == 8'h2E) || (in_data == 8'h2C);
  // The final RAM slot is reserved for the terminator.
  assign full   = (length_q == (ADDR_SIZE+1)'(SIZE-1));

  always_comb begin
    state_d      = state_q;
    length_d     = length_q;
    depth_d      = depth_q;
    overflow_d   = overflow_q;
    unbalanced_d = unbalanced_q;
    ram_addr_d   = ram_addr_q;
    ram_data_d   = ram_data_q;
    ram_write_d  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d      = LOAD;
          length_d     = '0;
          depth_d      = '0;
          overflow_d   = 1'b0;
          unbalanced_d = 1'b0;
        end
      end
      LOAD: begin
        if (accept) begin
          if (in_data == 8'h00 || (is_cmd && full)) begin
            // Terminator write is registered on entry so it is visible during TERM.
            state_d     = TERM;
            ram_write_d = 1'b1;
            ram_addr_d  = length_q[ADDR_SIZE-1:0];
            ram_data_d  = 8'h00;
            if (is_cmd) overflow_d = 1'b1;
            if (depth_q != '0) unbalanced_d = 1'b1;
          end else if (is_cmd) begin
            ram_write_d = 1'b1;
            ram_addr_d  = length_q[ADDR_SIZE-1:0];
            ram_data_d  = in_data;
            length_d    = length_q + 1'b1;
            if (in_data == 8'h5B) depth_d = depth_q + 1'b1;
            if (in_data == 8'h5D) begin
              if (depth_q == '0) unbalanced_d = 1'b1;
              else               depth_d      = depth_q - 1'b1;
            end
          end
        end
      end
      TERM:    state_d = SETTLE;
      SETTLE:  state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      length_q     <= '0;
      depth_q      <= '0;
      overflow_q   <= 1'b0;
      unbalanced_q <= 1'b0;
      ram_addr_q   <= '0;
      ram_data_q   <= '0;
      ram_write_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      length_q     <= length_d;
      depth_q      <= depth_d;
      overflow_q   <= overflow_d;
      unbalanced_q <= unbalanced_d;
      ram_addr_q   <= ram_addr_d;
      ram_data_q   <= ram_data_d;
      ram_write_q  <= ram_write_d;
    end
  end

  assign in_ready   = (state_q == LOAD);
  assign busy       = (state_q == LOAD) || (state_q == TERM) || (state_q == SETTLE);
  assign done       = (state_q == DONE);
  assign overflow   = overflow_q;
  assign unbalanced = unbalanced_q;
  assign length     = length_q;
  assign ram_addr   = ram_addr_q;
  assign ram_data   = ram_data_q;
  assign ram_write  = ram_write_q;

endmodule

// File: tb/tb_bf_program_loader.sv
// Directed bench for bf_program_loader (SIZE=8): scoreboarded RAM writes plus flag,
// timing and reset checks on a behavioural program RAM.
module tb_bf_program_loader;
  localparam int SIZE = 8;
  localparam int AW   = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_data;
  logic          ram_write;
  logic          busy, done, overflow, unbalanced;
  logic [AW:0]   length;

  bf_program_loader #(.SIZE(SIZE), .ADDR_SIZE(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .ram_addr(ram_addr), .ram_data(ram_data), .ram_write(ram_write),
    .busy(busy), .done(done), .overflow(overflow), .unbalanced(unbalanced), .length(length)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int fails   = 0;
  int wr_cnt  = 0;
  int m_len   = 0;
  logic [10:0] exp_q[$];
  logic [7:0]  mem [SIZE];
  logic        clr = 1'b0;

  always @(posedge clk) begin
    if (clr) for (int i = 0; i < SIZE; i++) mem[i] <= 8'hFF;
    else if (ram_write) mem[ram_addr] <= ram_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write pulse must match the next expected {addr,data}.
  always @(negedge clk) begin
    if (ram_write === 1'b1) begin
      wr_cnt++;
      if (exp_q.size() == 0) chk("unexpected_write", {21'd0, ram_addr, ram_data}, 32'h7FF);
      else begin
        logic [10:0] e;
        e = exp_q.pop_front();
        chk("ram_write_addr_data", {21'd0, ram_addr, ram_data}, {21'd0, e});
      end
    end
  end

  task automatic clear_mem();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    m_len = 0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_length", 32'(length), 32'd0);
  endtask

  // Push the expected write, then drive the byte until it is accepted (bounded).
  task automatic send(input logic [7:0] b, input int gap);
    logic cmd;
    logic ok;
    cmd = (b inside {8'h2B, 8'h2D, 8'h3C, 8'h3E, 8'h5B, 8'h5D, 8'h2E, 8'h2C});
    if (b == 8'h00) exp_q.push_back({m_len[AW-1:0], 8'h00});
    else if (cmd) begin
      if (m_len == SIZE-1) exp_q.push_back({m_len[AW-1:0], 8'h00});
      else begin exp_q.push_back({m_len[AW-1:0], b}); m_len++; end
    end
    for (int g = 0; g < gap; g++) @(negedge clk);
    in_valid = 1'b1; in_data = b; ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      if (in_ready) ok = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_str(input string s, input bit rnd);
    for (int i = 0; i < s.len(); i++) send(s[i], rnd ? int'($urandom_range(0, 2)) : 0);
  endtask

  task automatic wait_done();
    int c = 0;
    while (!done && c < 20) begin @(negedge clk); c++; end
    if (!done) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_mem(input string tag, input string s);
    for (int i = 0; i < s.len(); i++) chk(tag, 32'(mem[i]), 32'(s[i]));
    chk({tag, "_term"}, 32'(mem[s.len()]), 32'd0);
  endtask

  initial begin
    int w0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_ram_write", 32'(ram_write), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_ram_data", 32'(ram_data), 32'd0);
    chk("rst_busy_done", {30'd0, busy, done}, 32'd0);
    chk("rst_flags", {30'd0, overflow, unbalanced}, 32'd0);
    chk("rst_length", 32'(length), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Balanced program with terminator; done two cycles after the terminator write.
    clear_mem();
    pulse_start();
    send_str("+[->+<]", 0);
    send(8'h00, 0);
    chk("term_write_vis", 32'(ram_write), 32'd1);
    chk("term_done_lo", 32'(done), 32'd0);
    @(negedge clk);
    chk("settle_done_lo", {30'd0, done, ram_write}, 32'd0);
    chk("settle_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("done_hi", {30'd0, done, busy}, 32'b10);
    chk("done_in_ready", 32'(in_ready), 32'd0);
    check_mem("bal_mem", "+[->+<]");
    chk("bal_length", 32'(length), 32'd7);
    chk("bal_flags", {30'd0, overflow, unbalanced}, 32'd0);

    // Filtering of non-command bytes.
    clear_mem();
    pulse_start();
    w0 = wr_cnt;
    send_str("a+\n-Z", 0);
    send(8'h00, 0);
    wait_done();
    check_mem("filt_mem", "+-");
    chk("filt_length", 32'(length), 32'd2);
    chk("filt_writes", 32'(wr_cnt - w0), 32'd3);

    // Capacity overflow: 8th '+' is dropped and terminates the load.
    clear_mem();
    pulse_start();
    for (int i = 0; i < 8; i++) send(8'h2B, 0);
    chk("ovf_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1; in_data = 8'h2B;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    wait_done();
    check_mem("ovf_mem", "+++++++");
    chk("ovf_length", 32'(length), 32'd7);
    chk("ovf_flag", 32'(overflow), 32'd1);

    // Bracket errors.
    clear_mem();
    pulse_start();
    send_str("]][", 0);
    send(8'h00, 0);
    wait_done();
    check_mem("unb1_mem", "]][");
    chk("unb1_flag", 32'(unbalanced), 32'd1);
    chk("unb1_length", 32'(length), 32'd3);
    pulse_start();
    chk("unb_cleared", 32'(unbalanced), 32'd0);
    send_str("[[", 0);
    send(8'h00, 0);
    wait_done();
    chk("unb2_flag", {30'd0, unbalanced, overflow}, 32'b10);

    // Random in_valid gaps and ignored start pulses during LOAD.
    clear_mem();
    pulse_start();
    send_str("+[-", 1);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("start_in_load_length", 32'(length), 32'd3);
    send_str(">+<]", 1);
    send(8'h00, 1);
    wait_done();
    check_mem("rnd_mem", "+[->+<]");
    chk("rnd_length", 32'(length), 32'd7);
    chk("rnd_flags", {30'd0, overflow, unbalanced}, 32'd0);

    // Reset mid-load cancels a pending write.
    pulse_start();
    send_str("+-[", 0);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    chk("mid_rst_ram_write", 32'(ram_write), 32'd0);
    chk("mid_rst_addr_data", {21'd0, ram_addr, ram_data}, 32'd0);
    chk("mid_rst_state", {28'd0, in_ready, busy, done, overflow}, 32'd0);
    chk("mid_rst_length", {27'd0, unbalanced, length}, 32'd0);
    pulse_start();
    send_str("++", 0);
    send(8'h00, 0);
    wait_done();
    chk("post_rst_length", 32'(length), 32'd2);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
